// File: rtl/disable_timing_capture_checker.sv
// Capture-end checker: synchronizes the timing-disabled signal, delay-matches the timed one,
// and counts bitwise mismatches over a fixed window. Optional history: DISABLE_TIMING_CAPTURE_HIST_EN.
module disable_timing_capture_checker #(
  parameter int WINDOW      = 64,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int HIST_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           comb_in,
  input  logic                           reg_in,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [CNT_W-1:0]               err_count,
  output logic [$clog2(WINDOW+1)-1:0]    sample_count
`ifdef DISABLE_TIMING_CAPTURE_HIST_EN
  ,
  output logic [HIST_W-1:0]              mismatch_hist
`endif
);

  localparam int SC_W = $clog2(WINDOW + 1);
  localparam int FL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, CAPTURE, DONE_ST} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] comb_sync_q, reg_dly_q;
  logic [FL_W-1:0]        flush_q, flush_d;
  logic [SC_W-1:0]        sc_q, sc_d;
  logic [CNT_W-1:0]       err_q, err_d;
  logic                   pass_q, pass_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   mismatch;
`ifdef DISABLE_TIMING_CAPTURE_HIST_EN
  logic [HIST_W-1:0]      hist_q, hist_d;
`endif

  // Alignment: both paths see the same depth, so comb_s and reg_d refer to the same launch cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comb_sync_q <= '0;
      reg_dly_q   <= '0;
    end else begin
      comb_sync_q <= {comb_sync_q[SYNC_STAGES-2:0], comb_in};
      reg_dly_q   <= {reg_dly_q[SYNC_STAGES-2:0], reg_in};
    end
  end

  assign mismatch = comb_sync_q[SYNC_STAGES-1] ^ reg_dly_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    sc_d    = sc_q;
    err_d   = err_q;
    pass_d  = pass_q;
`ifdef DISABLE_TIMING_CAPTURE_HIST_EN
    hist_d  = hist_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FLUSH;
          flush_d = '0;
          sc_d    = '0;
          err_d   = '0;
          pass_d  = 1'b0;
`ifdef DISABLE_TIMING_CAPTURE_HIST_EN
          hist_d  = '0;
`endif
        end
      end
      FLUSH: begin
        // Wait until every pipeline stage holds a sample taken after start.
        if (flush_q == FL_W'(SYNC_STAGES - 1)) state_d = CAPTURE;
        else                                   flush_d = flush_q + FL_W'(1);
      end
      CAPTURE: begin
        sc_d = sc_q + SC_W'(1);
        if (mismatch) err_d = sat_inc(err_q);
`ifdef DISABLE_TIMING_CAPTURE_HIST_EN
        hist_d = {hist_q[HIST_W-2:0], mismatch};
`endif
        if (sc_q == SC_W'(WINDOW - 1)) begin
          state_d = DONE_ST;
          pass_d  = (err_d == '0);
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FLUSH) || (state_d == CAPTURE);
    done_d = (state_d == DONE_ST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= '0;
      sc_q    <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DISABLE_TIMING_CAPTURE_HIST_EN
      hist_q  <= '0;
`endif
    end else begin
      flush_q <= flush_d;
      sc_q    <= sc_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DISABLE_TIMING_CAPTURE_HIST_EN
      hist_q  <= hist_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign sample_count = sc_q;
`ifdef DISABLE_TIMING_CAPTURE_HIST_EN
  assign mismatch_hist = hist_q;
`endif

endmodule

// File: doc/disable_timing_capture_checker.md
Name: disable_timing_capture_checker

Overview:
- Receive-side companion for the disabled-timing benchmark. It captures two signals arriving from a launching block: one over a timing-disabled combinational path, and one over a normally timed registered path.
- The disabled-path signal is treated as asynchronous and passed through a synchronizer. The timed-path signal is delay-matched to it.
- Over a fixed window, the block compares the two aligned signals bit by bit and reports a mismatch count and a pass/fail verdict.
- It sits at the capture end of the benchmark so the effect of set_disable_timing can be observed functionally on hardware.

Parameters:
- WINDOW, 64, number of capture cycles compared per run (>=1).
- SYNC_STAGES, 2, synchronizer depth on comb_in; reg_in is delayed by the same depth (>=2).
- CNT_W, 8, width of err_count (saturating).
- HIST_W, 16, mismatch history width (used only with the optional feature).

Ports:
- clk  input  1  single clock; all state on posedge clk.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle run request; ignored while busy=1.
- comb_in  input  1  signal from the timing-disabled combinational path.
- reg_in  input  1  signal from the timed registered path.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  1 when the last run had err_count==0; held until the next start.
- err_count  output  CNT_W  mismatches in the last or current run; saturating.
- sample_count  output  $clog2(WINDOW+1)  capture cycles completed in the current run.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - Synchronizer, delay line, busy, done, pass, err_count and sample_count all go to 0.
  - Reset mid-run aborts the run and no done pulse is issued.
- Alignment:
  - comb_in passes through SYNC_STAGES flops to give comb_s.
  - reg_in passes through SYNC_STAGES flops to give reg_d.
  - The compare is mismatch = comb_s ^ reg_d.
  - Both pipelines run continuously in every state.
- FSM states:
  - IDLE: busy=0. If start=1, clear err_count, sample_count and pass, then go to FLUSH.
  - FLUSH: busy=1. Lasts exactly SYNC_STAGES cycles so that the pipelines hold only post-start samples. No comparisons are made. Then go to CAPTURE.
  - CAPTURE: busy=1. Lasts exactly WINDOW cycles.
    - Every cycle, sample_count increments.
    - If mismatch=1, err_count increments, saturating at 2^CNT_W-1 (no wrap).
    - After the WINDOW-th capture cycle, go to DONE.
  - DONE: busy=0 and done=1 for exactly one cycle. pass = (err_count==0) is latched. Go to IDLE.
- Latency: if start is sampled at edge k, busy rises after edge k and done is high during cycle k+SYNC_STAGES+WINDOW+1.
- start during FLUSH, CAPTURE or DONE is ignored; there is no queuing.
- start asserted in IDLE in the cycle immediately after DONE is accepted normally.
- sample_count holds at WINDOW after the run completes and clears on the next accepted start.
- Saturation: err_count stays at its maximum value. pass=0 whenever err_count is non-zero, including the saturated case.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: DISABLE_TIMING_CAPTURE_HIST_EN.
- Defined:
  - Adds output port mismatch_hist [HIST_W-1:0].
  - During CAPTURE, each cycle shifts left by one and loads mismatch into bit 0.
  - Cleared on an accepted start and on reset.
  - Holds its value outside CAPTURE.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Equal pattern, no errors. Set WINDOW=8, SYNC_STAGES=2, CNT_W=4. Drive comb_in=reg_in=10110010 repeating and pulse start at edge 0. Required: busy=1 for cycles 1-10, done=1 in cycle 11, pass=1, err_count=0, sample_count=8.
- Full mismatch. Same parameters, comb_in=1 constant, reg_in=0 constant, start pulse. Required: err_count=8, pass=0, done in cycle 11.
- Saturation. Set WINDOW=32, CNT_W=4, inputs mismatched every cycle. Required: err_count=15 (no wrap), pass=0.
- Start while busy. With WINDOW=8, pulse start at edge 0 and again at edges 4 and 11. Required: the edge-4 start is ignored and done still occurs in cycle 11. The edge-11 start is also ignored because the FSM is in DONE. A new start at edge 12 gives done in cycle 23.
- Reset mid-run. Deassert rst_n during CAPTURE cycle 5. Required: busy, err_count, sample_count and pass are 0 immediately, with no done pulse. After rst_n releases, a fresh start completes normally.
- Optional feature. Define DISABLE_TIMING_CAPTURE_HIST_EN with WINDOW=8 and HIST_W=16. Inject a mismatch only on capture cycle index 3 (0-based). Required: mismatch_hist=16'h0010, err_count=1, pass=0.
